// File: rtl/mac_sequencer.sv
// mac_sequencer: front-end controller for the neuron MAC datapath.
// Holds a small weight bank, pairs each accepted input sample with its tap
// weight, and reports the dot product as the accumulator difference between
// the end and the start of a vector (the MAC itself cannot be cleared).
module mac_sequencer #(
    parameter int N_TAPS = 4,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_we,
    input  logic [IDX_W-1:0]        w_addr,
    input  logic signed [7:0]       w_data,
    input  logic                    start,
    output logic                    busy,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic signed [7:0]       x_data,
    output logic signed [7:0]       mac_x,
    output logic signed [7:0]       mac_w,
    input  logic signed [15:0]      mac_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [15:0]      res_data
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CAPT,
        DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [IDX_W-1:0]         r_idx;
    logic signed [15:0]       r_base;
    logic signed [15:0]       r_resData;
    logic signed [7:0]        r_macX;
    logic signed [7:0]        r_macW;
    logic signed [7:0]        r_weight [2**IDX_W];

    logic                     w_accept;
    logic                     w_lastTap;
    logic                     w_wrEn;

    // Only addresses inside the configured tap range may touch the bank.
    assign w_wrEn    = w_we && ({1'b0, w_addr} < (IDX_W+1)'(N_TAPS));
    assign w_accept  = (r_state == RUN) && x_valid;
    assign w_lastTap = (r_idx == IDX_W'(N_TAPS - 1));

    assign busy      = (r_state != IDLE);
    assign x_ready   = (r_state == RUN);
    assign res_valid = (r_state == DONE);
    assign res_data  = r_resData;
    assign mac_x     = r_macX;
    assign mac_w     = r_macW;

    // State register; reset abandons any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: DRAIN lets the MAC absorb the last pair, CAPT reads the sum.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_accept && w_lastTap) w_nextState = DRAIN;
            DRAIN:   w_nextState = CAPT;
            CAPT:    w_nextState = DONE;
            DONE:    if (res_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Weight bank writes; a pairing on the same edge still reads the old weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                r_weight[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_weight[w_addr] <= w_data;
        end
    end

    // Datapath: pairs are zero except the cycle after a handshake, so idle adds nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_base    <= '0;
            r_resData <= '0;
            r_macX    <= '0;
            r_macW    <= '0;
        end else begin
            r_macX <= '0;
            r_macW <= '0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base <= mac_out;
                        r_idx  <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_macX <= x_data;
                        r_macW <= r_weight[r_idx];
                        if (!w_lastTap) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                CAPT: begin
                    r_resData <= mac_out - r_base;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed vectors with a result scoreboard and a
// behavioural accumulator standing in for the downstream MAC.
module tb_mac_sequencer;

    localparam int N_TAPS = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               w_we = 1'b0;
    logic [3:0]         w_addr = '0;
    logic signed [7:0]  w_data = '0;
    logic               start = 1'b0;
    logic               busy;
    logic               x_valid = 1'b0;
    logic               x_ready;
    logic signed [7:0]  x_data = '0;
    logic signed [7:0]  mac_x;
    logic signed [7:0]  mac_w;
    logic signed [15:0] acc;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic signed [15:0] res_data;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    int vec[4];

    mac_sequencer #(.N_TAPS(N_TAPS), .IDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .start     (start),
        .busy      (busy),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .mac_x     (mac_x),
        .mac_w     (mac_w),
        .mac_out   (acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    // Downstream MAC: accumulates every registered pair, wraps mod 2^16, shares rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= acc + 16'(mac_x) * 16'(mac_w);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every accepted result is compared with the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                checkOutput("res_data", res_data, expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWeight(input logic [3:0] addr, input int data);
        w_we   = 1'b1;
        w_addr = addr;
        w_data = 8'(data);
        tick();
        w_we   = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_x_ready"}, x_ready, 0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_res_data"}, res_data, 0);
        checkOutput({tag, "_mac_x"}, mac_x, 0);
        checkOutput({tag, "_mac_w"}, mac_w, 0);
    endtask

    // Runs one vector from vec[]; optional gaps, result stall, and a weight write on one handshake.
    task automatic applyStimulus(input int gap, input int expected, input int stall,
                                 input int wrIdx, input logic [3:0] wrAddr, input int wrData);
        expQ.push_back(expected);
        res_ready = (stall == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("x_ready_run", x_ready, 1);
        for (int i = 0; i < 4; i++) begin
            x_valid = 1'b1;
            x_data  = 8'(vec[i]);
            if (i == wrIdx) begin
                w_we   = 1'b1;
                w_addr = wrAddr;
                w_data = 8'(wrData);
            end
            tick();
            x_valid = 1'b0;
            w_we    = 1'b0;
            checkOutput("mac_x_pair", mac_x, vec[i]);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    checkOutput("mac_x_gap", mac_x, 0);
                    checkOutput("mac_w_gap", mac_w, 0);
                end
            end
        end
        checkOutput("x_ready_drain", x_ready, 0);
        tick();
        checkOutput("x_ready_capt", x_ready, 0);
        checkOutput("res_valid_capt", res_valid, 0);
        tick();
        checkOutput("res_valid_latency", res_valid, 1);
        if (stall != 0) begin
            for (int s = 0; s < 5; s++) begin
                start = 1'b1;
                tick();
                checkOutput("stall_res_valid", res_valid, 1);
                checkOutput("stall_res_data", res_data, expected);
                checkOutput("stall_x_ready", x_ready, 0);
                checkOutput("stall_busy", busy, 1);
            end
            start     = 1'b0;
            res_ready = 1'b1;
        end
        tick();
        checkOutput("busy_after_result", busy, 0);
        checkOutput("res_valid_after", res_valid, 0);
    endtask

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        tick();
        checkReset("reset");
        rst_n = 1'b1;
        tick();

        // Basic vector, back-to-back samples.
        writeWeight(0, 1); writeWeight(1, 2); writeWeight(2, 3); writeWeight(3, 4);
        vec = '{10, 20, 30, 40};
        applyStimulus(0, 300, 0, -1, 0, 0);

        // Same weights from a nonzero accumulator, one idle cycle between samples.
        vec = '{1, 1, 1, 1};
        applyStimulus(1, 10, 0, -1, 0, 0);

        // Products of 16384 sum to 65536, wrapping to zero.
        writeWeight(0, -128); writeWeight(1, -128); writeWeight(2, -128); writeWeight(3, -128);
        vec = '{-128, -128, -128, -128};
        applyStimulus(0, 0, 0, -1, 0, 0);

        // Mixed-sign weights.
        writeWeight(0, -1); writeWeight(1, 2); writeWeight(2, -3); writeWeight(3, 4);
        vec = '{5, 5, 5, 5};
        applyStimulus(0, 10, 0, -1, 0, 0);

        // Result held off for 5 cycles with start pulsed in DONE: -3+2-3+8 = 4.
        vec = '{3, 1, 1, 2};
        applyStimulus(0, 4, 1, -1, 0, 0);

        // Write weight[1]=7 on the idx=1 handshake: that pair still uses 2 -> 1+6+3+4 = 14.
        writeWeight(0, 1); writeWeight(1, 2); writeWeight(2, 3); writeWeight(3, 4);
        vec = '{1, 3, 1, 1};
        applyStimulus(0, 14, 0, 1, 1, 7);
        vec = '{0, 1, 0, 0};
        applyStimulus(0, 7, 0, -1, 0, 0);

        // Out-of-range writes are dropped: 1+7+3+4 = 15.
        writeWeight(4, 100);
        writeWeight(15, 100);
        vec = '{1, 1, 1, 1};
        applyStimulus(0, 15, 0, -1, 0, 0);

        // Reset after two of four samples: outputs and weights return to zero.
        start = 1'b1;
        tick();
        start = 1'b0;
        x_valid = 1'b1;
        x_data  = 8'sd1;
        tick();
        tick();
        x_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        vec = '{1, 1, 1, 1};
        applyStimulus(0, 0, 0, -1, 0, 0);

        tick();
        tick();
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Front-end controller for the neuron MAC datapath. It holds a programmable bank of N_TAPS signed 8-bit weights and accepts a stream of signed 8-bit input samples over a valid/ready handshake. Each accepted sample is paired with its weight and driven into the downstream MAC as a registered x/weight pair. After a full vector it returns the dot product on a result handshake. The MAC has no clear input, so the result is computed as the accumulator value at the end of the vector minus the value snapshotted at start, modulo 2^16.

Parameters:
N_TAPS, 4, number of taps per vector; legal range 1..16
IDX_W, 4, width of weight address and internal tap index; fixed at 4 to cover the maximum of 16 taps

Ports:
clk  input  1  single system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
w_we  input  1  weight write enable
w_addr  input  4  weight write address
w_data  input  8  signed weight write data
start  input  1  begin a vector; sampled only in IDLE
busy  output  1  high whenever state is not IDLE
x_valid  input  1  input sample valid
x_ready  output  1  sequencer can accept a sample
x_data  input  8  signed input sample
mac_x  output  8  signed registered sample to the MAC
mac_w  output  8  signed registered weight to the MAC
mac_out  input  16  signed MAC accumulator value
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  16  signed dot-product result

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; idx=0; base=0.
  - All weights=0; mac_x=0, mac_w=0.
  - res_valid=0, res_data=0, x_ready=0, busy=0.
- Reset mid-operation: the vector is abandoned and no result is produced. The MAC shares rst_n.
- Weight writes:
  - Accepted in any state when w_we=1 and w_addr<N_TAPS; the write lands at the clock edge.
  - Writes with w_addr>=N_TAPS are ignored.
  - A pairing on the same edge as a write to the same address uses the old weight.
- mac_x/mac_w are registered. They equal 0 on every cycle except the one cycle following an accepted sample, so the MAC adds 0 while the sequencer is idle or stalled.
- State machine:
  - IDLE: x_ready=0. If start=1: base<=mac_out, idx<=0, go to RUN.
  - RUN: x_ready=1.
    - On x_valid&&x_ready: mac_x<=x_data, mac_w<=weight[idx].
    - If idx==N_TAPS-1, go to DRAIN; otherwise idx<=idx+1.
    - With no handshake: pair<=0, stay in RUN (stalls of any length are allowed).
  - DRAIN, one cycle: x_ready=0, pair<=0. The MAC absorbs the last pair on this edge. Go to CAPT.
  - CAPT, one cycle: res_data<=mac_out-base (16-bit wrap), res_valid<=1, go to DONE.
  - DONE: res_valid=1 and res_data stable until res_ready=1; then res_valid<=0 and go to IDLE.
- Latency: the last sample is accepted at edge E; res_valid rises at edge E+2. A result accepted at edge F allows start to be accepted at F+1 or later.
- start is ignored whenever busy=1, including in DONE.
- Arithmetic:
  - Products and accumulation wrap mod 2^16, matching the MAC.
  - The subtraction is exact mod 2^16, so the result is correct for any nonzero accumulator starting value, including across wrap.
  - No saturation.
- N_TAPS=1: RUN goes to DRAIN on the first accepted sample.

Test Plan:
- Weights {1,2,3,4}, fresh reset; start; x=10,20,30,40 back-to-back -> res_valid two edges after the 4th handshake, res_data=300; busy low after res_ready.
- Following the previous run (accumulator=300), x=1,1,1,1 with one idle cycle between each -> res_data=10; mac_x/mac_w are 0 during gaps; x_ready low in DRAIN/CAPT.
- All weights=-128, x=-128 x4 -> each product is 16384, sum 65536 wraps -> res_data=0. Weights {-1,2,-3,4}, x={5,5,5,5} -> res_data=10.
- Hold res_ready low for 5 cycles with start pulsed during DONE -> res_valid and res_data stay stable, start is ignored, x_ready=0; after res_ready the FSM returns to IDLE and the next start is accepted.
- During RUN at idx=1, write weight[1]=7 on the handshake edge (old value 2, x=3) -> pair uses 2. Write to w_addr=N_TAPS -> no effect on any later result.
- Assert rst_n low after 2 of 4 samples -> all outputs read their reset values immediately. After release, start with x={1,1,1,1} -> res_data=0, because weights were reset to 0.
